// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    // Memory-access tracking states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    // Default maximum MEM_WAIT cycles before a hung access is trapped.
    localparam int WAIT_MAX_DEF = 15;
    // Default width of each performance counter.
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the performance event counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: step by one on an event, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: resolves load-use, taken-branch and slow-memory
// hazards, traps hung memory accesses and counts hazard events.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       RD_E,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] MemWaitCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    state_e          state_d;
    state_e          state_q;
    logic [WC_W-1:0] wait_cnt_d;
    logic [WC_W-1:0] wait_cnt_q;

    logic mem_stall;
    logic lu_hit;
    logic act_mem;
    logic act_br;
    logic act_lu;

    // Raw hazard detection; ERROR keeps the whole front end frozen.
    always_comb begin
        mem_stall = (state_q == ERROR) | (MemReqM & ~MemReadyM);
        lu_hit    = ResultSrcE0 & (RD_E != 5'd0) &
                    ((RD_E == Rs1_D) | (RD_E == Rs2_D));
    end

    // Prioritised stall/flush decode; everything is held low during reset.
    always_comb begin
        act_mem = 1'b0;
        act_br  = 1'b0;
        act_lu  = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                // Execute is frozen, so branch and load-use are irrelevant.
                act_mem = 1'b1;
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                StallM  = 1'b1;
                FlushW  = 1'b1;
            end else if (PCSrcE) begin
                // The Decode instruction is discarded, so no load-use stall.
                act_br  = 1'b1;
                FlushD  = 1'b1;
                FlushE  = 1'b1;
            end else if (lu_hit) begin
                act_lu  = 1'b1;
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE  = 1'b1;
            end
        end
    end

    // Memory-wait FSM next state and timeout counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(WAIT_MAX)) begin
                    state_d    = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Sticky timeout flag: only reset leaves ERROR.
    assign MemTimeout = (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (act_lu),
        .q   (LoadUseCnt)
    );

    sat_counter #(.W(CNT_W)) u_mw_cnt (
        .clk (clk),
        .rst (rst),
        .inc (act_mem),
        .q   (MemWaitCnt)
    );

    sat_counter #(.W(CNT_W)) u_fl_cnt (
        .clk (clk),
        .rst (rst),
        .inc (act_br),
        .q   (FlushCnt)
    );

endmodule
